// File: rtl/abr_sib_pkg.sv
// abr_sib_pkg: shared types and constants for the SampleInBall controller.
//   SIB_SAMPLE_W : bits per rejection sample (one SHAKE256 byte)
//   N / IDX_W    : challenge polynomial length and its index width
//   SIGN_W       : number of sign bits captured ahead of the samples
//   sib_state_e  : controller FSM states
//   sib_swap_t   : one swap command {i, j, sign} for the polynomial writer
package abr_sib_pkg;

  localparam int SIB_SAMPLE_W = 8;
  localparam int N            = 256;
  localparam int IDX_W        = 8;
  localparam int SIGN_W       = 64;

  typedef enum logic [1:0] {
    SIB_IDLE   = 2'd0,
    SIB_SIGN   = 2'd1,
    SIB_SAMPLE = 2'd2,
    SIB_DONE   = 2'd3
  } sib_state_e;

  typedef struct packed {
    logic [IDX_W-1:0] i;
    logic [IDX_W-1:0] j;
    logic             sign;
  } sib_swap_t;

endpackage

// File: rtl/sample_in_ball.sv
// sample_in_ball: single-sample rejection comparator.
//   valid_i     : sample present
//   data_i      : candidate index j (one SHAKE byte)
//   rej_value_i : current destination index i
//   pass_o      : sample accepted (valid and j <= i, unsigned)
module sample_in_ball
  import abr_sib_pkg::*;
(
  input  logic                    valid_i,
  input  logic [SIB_SAMPLE_W-1:0] data_i,
  input  logic [IDX_W-1:0]        rej_value_i,
  output logic                    pass_o
);

  assign pass_o = valid_i & (data_i <= rej_value_i);

endmodule

// File: rtl/sib_lane_buffer.sv
// sib_lane_buffer: holds one SHAKE word and walks its byte lanes in order.
//   clk, rst : clock, asynchronous active-high reset
//   clear    : synchronous flush (buffer becomes empty)
//   load     : capture word_i, pointer to lane 0
//   word_i   : incoming word, lane 0 in the low byte
//   consume  : current lane is done; advance or empty after the last lane
//   full_o   : a lane is available
//   last_o   : current lane is the last lane of the word
//   lane_o   : current lane byte
module sib_lane_buffer
  import abr_sib_pkg::*;
#(
  parameter int NUM_SAMPLES = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                clear,
  input  logic                                load,
  input  logic [NUM_SAMPLES*SIB_SAMPLE_W-1:0] word_i,
  input  logic                                consume,
  output logic                                full_o,
  output logic                                last_o,
  output logic [SIB_SAMPLE_W-1:0]             lane_o
);

  localparam int WORD_W = NUM_SAMPLES * SIB_SAMPLE_W;
  localparam int PTR_W  = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1;

  logic [WORD_W-1:0] word_q;
  logic [PTR_W-1:0]  ptr_q;
  logic              full_q;

  assign full_o = full_q;
  assign last_o = full_q & (ptr_q == PTR_W'(NUM_SAMPLES - 1));
  assign lane_o = word_q[ptr_q*SIB_SAMPLE_W +: SIB_SAMPLE_W];

  // load wins over consume: the owner only loads when the buffer is empty
  // or its last lane is being consumed in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q <= '0;
      ptr_q  <= '0;
      full_q <= 1'b0;
    end else if (clear) begin
      word_q <= '0;
      ptr_q  <= '0;
      full_q <= 1'b0;
    end else if (load) begin
      word_q <= word_i;
      ptr_q  <= '0;
      full_q <= 1'b1;
    end else if (consume && full_q) begin
      if (last_o) begin
        full_q <= 1'b0;
        ptr_q  <= '0;
      end else begin
        ptr_q <= ptr_q + PTR_W'(1);
      end
    end
  end

endmodule

// File: rtl/sample_in_ball_ctrl.sv
// sample_in_ball_ctrl: sequential SampleInBall controller for ML-DSA.
// Captures 64 sign bits from the SHAKE256 stream, then rejection-samples
// j <= i for i = N-TAU .. N-1 and issues one swap command per accepted sample.
//   clk, rst      : clock, asynchronous active-high reset
//   zeroize       : synchronous clear of all state and outputs
//   start_i       : begin an operation (ignored while busy)
//   data_valid_i / data_i / data_ready_o : SHAKE word stream, lane 0 = low byte
//   swap_valid_o / swap_i_o / swap_j_o / swap_sign_o / swap_ready_i :
//                   registered single-entry swap command slot
//   busy_o        : operation in progress
//   done_o        : one-cycle pulse after the final swap is accepted
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; once raised, valid and its payload stay stable until that edge.
module sample_in_ball_ctrl
  import abr_sib_pkg::*;
#(
  parameter int NUM_SAMPLES = 4,
  parameter int TAU         = 60
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                zeroize,
  input  logic                                start_i,
  input  logic                                data_valid_i,
  input  logic [NUM_SAMPLES*SIB_SAMPLE_W-1:0] data_i,
  output logic                                data_ready_o,
  output logic                                swap_valid_o,
  output logic [IDX_W-1:0]                    swap_i_o,
  output logic [IDX_W-1:0]                    swap_j_o,
  output logic                                swap_sign_o,
  input  logic                                swap_ready_i,
  output logic                                busy_o,
  output logic                                done_o
);

  localparam int WORD_W     = NUM_SAMPLES * SIB_SAMPLE_W;
  localparam int SIGN_WORDS = SIGN_W / WORD_W;
  localparam logic [IDX_W-1:0] I_START = IDX_W'(N - TAU);
  localparam logic [IDX_W-1:0] I_LAST  = IDX_W'(N - 1);

  sib_state_e        state_q;
  logic [IDX_W-1:0]  i_q;
  logic [3:0]        sign_cnt_q;
  logic [SIGN_W-1:0] sign_q;
  sib_swap_t         swap_q;
  logic              swap_valid_q;
  logic              busy_q;
  logic              done_q;
  // Set once the i = N-1 swap sits in the slot; freezes lane evaluation.
  logic              final_q;

  logic                    lane_valid;
  logic                    lane_last;
  logic [SIB_SAMPLE_W-1:0] lane_data;
  logic                    in_sample;
  logic                    eval;
  logic                    pass;
  logic                    slot_free;
  logic                    consume;
  logic                    final_pass;
  logic                    swap_hs;
  logic                    final_hs;
  logic                    buf_load;
  logic                    buf_clear;
  logic [5:0]              sign_idx;

  assign in_sample  = (state_q == SIB_SAMPLE);
  assign eval       = in_sample & lane_valid & ~final_q;
  assign slot_free  = ~swap_valid_q | swap_ready_i;
  // A passing lane waits for the slot; a rejected lane is always dropped.
  assign consume    = eval & (~pass | slot_free);
  assign final_pass = pass & (i_q == I_LAST);
  assign swap_hs    = swap_valid_q & swap_ready_i;
  assign final_hs   = swap_hs & final_q;
  assign sign_idx   = 6'(i_q - I_START);

  // Refill in the same cycle the last lane leaves, so words stream without a
  // bubble; never refill behind the final accepted sample.
  assign data_ready_o = (state_q == SIB_SIGN) |
                        (in_sample & ~final_q &
                         (~lane_valid | (lane_last & consume & ~final_pass)));

  assign buf_load  = in_sample & data_valid_i & data_ready_o;
  assign buf_clear = zeroize | final_hs;

  sib_lane_buffer #(
    .NUM_SAMPLES (NUM_SAMPLES)
  ) u_lane_buffer (
    .clk     (clk),
    .rst     (rst),
    .clear   (buf_clear),
    .load    (buf_load),
    .word_i  (data_i),
    .consume (consume),
    .full_o  (lane_valid),
    .last_o  (lane_last),
    .lane_o  (lane_data)
  );

  sample_in_ball u_cmp (
    .valid_i     (eval),
    .data_i      (lane_data),
    .rej_value_i (i_q),
    .pass_o      (pass)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= SIB_IDLE;
      i_q          <= '0;
      sign_cnt_q   <= '0;
      sign_q       <= '0;
      swap_q       <= '0;
      swap_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      final_q      <= 1'b0;
    end else if (zeroize) begin
      state_q      <= SIB_IDLE;
      i_q          <= '0;
      sign_cnt_q   <= '0;
      sign_q       <= '0;
      swap_q       <= '0;
      swap_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      final_q      <= 1'b0;
    end else begin
      case (state_q)
        SIB_IDLE: begin
          if (start_i) begin
            state_q    <= SIB_SIGN;
            i_q        <= I_START;
            sign_cnt_q <= '0;
            busy_q     <= 1'b1;
          end
        end
        SIB_SIGN: begin
          if (data_valid_i) begin
            sign_q[sign_cnt_q*WORD_W +: WORD_W] <= data_i;
            sign_cnt_q <= sign_cnt_q + 4'd1;
            if (sign_cnt_q == 4'(SIGN_WORDS - 1)) begin
              state_q <= SIB_SAMPLE;
            end
          end
        end
        SIB_SAMPLE: begin
          if (final_hs) begin
            state_q      <= SIB_DONE;
            done_q       <= 1'b1;
            swap_valid_q <= 1'b0;
            final_q      <= 1'b0;
          end else if (consume && pass) begin
            swap_valid_q <= 1'b1;
            swap_q.i     <= i_q;
            swap_q.j     <= lane_data;
            swap_q.sign  <= sign_q[sign_idx];
            // i stops at N-1; the pending final swap ends the operation.
            if (final_pass) begin
              final_q <= 1'b1;
            end else begin
              i_q <= i_q + IDX_W'(1);
            end
          end else if (swap_ready_i) begin
            swap_valid_q <= 1'b0;
          end
        end
        SIB_DONE: begin
          state_q <= SIB_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= SIB_IDLE;
      endcase
    end
  end

  assign swap_valid_o = swap_valid_q;
  assign swap_i_o     = swap_q.i;
  assign swap_j_o     = swap_q.j;
  assign swap_sign_o  = swap_q.sign;
  assign busy_o       = busy_q;
  assign done_o       = done_q;

endmodule

// File: tb/tb_sample_in_ball_ctrl.sv
// Testbench for sample_in_ball_ctrl (NUM_SAMPLES=4, TAU=60).
module tb_sample_in_ball_ctrl;

  logic        clk;
  logic        rst;
  logic        zeroize;
  logic        start_i;
  logic        data_valid_i;
  logic [31:0] data_i;
  logic        data_ready_o;
  logic        swap_valid_o;
  logic [7:0]  swap_i_o;
  logic [7:0]  swap_j_o;
  logic        swap_sign_o;
  logic        swap_ready_i;
  logic        busy_o;
  logic        done_o;

  int total = 0;
  int bad   = 0;

  // Expected swaps packed as {i, j, sign}.
  logic [16:0] exp_q[$];
  logic [31:0] words[$];

  typedef struct {
    logic [63:0] sign;
    int          pattern;
    int          mode;    // 0: ready always high, 1: 10-cycle stall at first swap
    logic [7:0]  fi;      // first swap i
    logic [7:0]  fj;      // first swap j
    logic        fs;      // first swap sign
    logic        ls;      // sign of the i=255 swap
    int          lat;     // cycles from start edge to first swap_valid_o
  } vec_t;

  vec_t vecs[5];

  sample_in_ball_ctrl #(
    .NUM_SAMPLES (4),
    .TAU         (60)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .zeroize      (zeroize),
    .start_i      (start_i),
    .data_valid_i (data_valid_i),
    .data_i       (data_i),
    .data_ready_o (data_ready_o),
    .swap_valid_o (swap_valid_o),
    .swap_i_o     (swap_i_o),
    .swap_j_o     (swap_j_o),
    .swap_sign_o  (swap_sign_o),
    .swap_ready_i (swap_ready_i),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pat_byte(input int p, input int k);
    int v;
    case (p)
      0: return 8'h00;
      1: return (k == 0) ? 8'hFF : ((k == 1) ? 8'h05 : 8'h00);
      2: begin
        v = (k * 37 + 200) % 256;
        return v[7:0];
      end
      3: return (k < 2) ? 8'hFF : 8'h00;
      default: return 8'h00;
    endcase
  endfunction

  // ---------------- driver: one full operation ----------------
  task automatic run_op(input int r, input int abort_at, input int glitch_cyc);
    logic [31:0] w;
    logic [7:0]  b;
    logic [16:0] prev;
    logic [16:0] got;
    logic [16:0] exp;
    logic [63:0] sgn;
    int mi, last_idx, exp_words, exp_n;
    int wp, n_hs, cyc, first_cyc, stall_cnt, release_cyc, done_cyc;
    bit mdone, done_seen, prev_stall;

    sgn = vecs[r].sign;
    words.delete();
    exp_q.delete();
    words.push_back(sgn[31:0]);
    words.push_back(sgn[63:32]);
    w = '0;
    for (int k = 0; k < 128; k++) begin
      w[8*(k%4) +: 8] = pat_byte(vecs[r].pattern, k);
      if (k % 4 == 3) words.push_back(w);
    end
    // Reference: SampleInBall acceptance over the byte stream.
    mi = 196;
    mdone = 0;
    last_idx = 0;
    for (int k = 0; k < 128; k++) begin
      b = pat_byte(vecs[r].pattern, k);
      if (!mdone && int'(b) <= mi) begin
        exp_q.push_back({mi[7:0], b, sgn[mi-196]});
        if (mi == 255) begin
          mdone = 1;
          last_idx = k;
        end else begin
          mi++;
        end
      end
    end
    exp_words = 2 + last_idx / 4 + 1;
    exp_n = exp_q.size();

    wp = 0; n_hs = 0; cyc = 0; first_cyc = -1; stall_cnt = 0;
    release_cyc = -1; done_cyc = -1; done_seen = 0; prev_stall = 0; prev = '0;

    @(negedge clk);
    start_i = 1'b1;
    data_valid_i = 1'b0;
    swap_ready_i = 1'b1;

    while (!done_seen && cyc < 400) begin
      @(negedge clk);
      cyc++;
      start_i = (cyc == glitch_cyc);
      data_valid_i = (wp < words.size());
      data_i = (wp < words.size()) ? words[wp] : 32'h0;
      if (vecs[r].mode == 1 && stall_cnt < 10 && (stall_cnt > 0 || swap_valid_o)) begin
        swap_ready_i = 1'b0;
        stall_cnt++;
      end else begin
        swap_ready_i = 1'b1;
        if (vecs[r].mode == 1 && stall_cnt == 10 && release_cyc < 0) release_cyc = cyc;
      end
      #1;
      got = {swap_i_o, swap_j_o, swap_sign_o};
      if (cyc == 1) check("busy_after_start", busy_o, 1);
      if (swap_valid_o && first_cyc < 0) begin
        first_cyc = cyc;
        check("first_swap_latency", first_cyc, vecs[r].lat);
      end
      if (prev_stall) check("stalled_fields_stable", got, prev);
      if (!swap_ready_i && swap_valid_o) check("ready_low_while_stalled", data_ready_o, 0);
      prev_stall = swap_valid_o & ~swap_ready_i;
      prev = got;
      if (done_o) begin
        done_seen = 1;
        done_cyc = cyc;
        check("busy_during_done", busy_o, 1);
        check("ready_during_done", data_ready_o, 0);
      end
      if (swap_valid_o && swap_ready_i) begin
        if (exp_q.size() == 0) begin
          check("unexpected_swap", got, 17'h0);
        end else begin
          exp = exp_q.pop_front();
          check("swap_cmd", got, exp);
        end
        if (n_hs == 0) begin
          check("first_swap_i", swap_i_o, vecs[r].fi);
          check("first_swap_j", swap_j_o, vecs[r].fj);
          check("first_swap_sign", swap_sign_o, vecs[r].fs);
        end
        if (swap_i_o == 8'd255) check("last_swap_sign", swap_sign_o, vecs[r].ls);
        n_hs++;
      end
      if (data_valid_i && data_ready_o) wp++;
      if (abort_at > 0 && n_hs == abort_at) begin
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_busy_low", busy_o, 0);
        check("rst_swap_valid_low", swap_valid_o, 0);
        check("rst_ready_low", data_ready_o, 0);
        @(negedge clk);
        rst = 1'b0;
        data_valid_i = 1'b0;
        swap_ready_i = 1'b0;
        exp_q.delete();
        return;
      end
    end

    if (!done_seen) check("done_timeout", 0, 1);
    check("swap_count", n_hs, exp_n);
    check("words_accepted", wp, exp_words);
    if (vecs[r].mode == 1) check("one_swap_per_cycle", done_cyc - release_cyc, 60);

    for (int p = 0; p < 3; p++) begin
      @(negedge clk);
      data_valid_i = 1'b1;
      data_i = 32'h0;
      swap_ready_i = 1'b1;
      #1;
      check("post_done_pulse", done_o, 0);
      check("post_ready_low", data_ready_o, 0);
      check("post_busy_low", busy_o, 0);
      check("post_swap_valid", swap_valid_o, 0);
    end
    data_valid_i = 1'b0;
    swap_ready_i = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    vecs[0] = '{64'hDEAD_BEEF_0123_4567, 0, 0, 8'd196, 8'd0,  1'b1, 1'b1, 5};
    vecs[1] = '{64'h0000_0000_0000_0001, 1, 0, 8'd196, 8'd5,  1'b1, 1'b0, 6};
    vecs[2] = '{64'h0123_4567_89AB_CDEE, 2, 0, 8'd196, 8'd18, 1'b0, 1'b0, 7};
    vecs[3] = '{64'hFFFF_FFFF_FFFF_FFFE, 3, 0, 8'd196, 8'd0,  1'b0, 1'b1, 7};
    vecs[4] = '{64'h5555_5555_5555_5555, 0, 1, 8'd196, 8'd0,  1'b1, 1'b0, 5};

    rst = 1'b1;
    zeroize = 1'b0;
    start_i = 1'b0;
    data_valid_i = 1'b0;
    data_i = '0;
    swap_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_busy", busy_o, 0);
    check("reset_done", done_o, 0);
    check("reset_swap_valid", swap_valid_o, 0);
    check("reset_ready", data_ready_o, 0);
    check("reset_swap_fields", {swap_i_o, swap_j_o, swap_sign_o}, 17'h0);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven operations.
    for (int r = 0; r < 5; r++) run_op(r, 0, 0);

    // rst while the slot holds i=220, then a clean restart from i=196.
    run_op(0, 24, 0);
    run_op(0, 0, 0);

    // start_i pulsed mid-SAMPLE must not disturb the sequence.
    run_op(2, 0, 20);

    // zeroize during SIGN.
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    data_valid_i = 1'b1;
    data_i = 32'hFFFF_FFFF;
    #1;
    check("sign_state_ready", data_ready_o, 1);
    @(negedge clk);
    data_valid_i = 1'b0;
    zeroize = 1'b1;
    @(negedge clk);
    zeroize = 1'b0;
    #1;
    check("zeroize_busy", busy_o, 0);
    check("zeroize_ready", data_ready_o, 0);
    check("zeroize_sign_reg", dut.sign_q, 64'h0);

    // After zeroize a fresh operation still behaves normally.
    run_op(1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sample_in_ball_ctrl.md
# sample_in_ball_ctrl

Sequential SampleInBall controller for ML-DSA challenge-polynomial generation. It consumes the SHAKE256 output stream as multi-byte words, captures the 64 sign bits, and rejection-samples positions j ≤ i for i = 256−TAU … 255. For each accepted sample it emits one swap command (c[i] ← c[j], c[j] ← ±1) to the downstream polynomial-memory writer. It sits between the Keccak output FIFO and the challenge-polynomial memory port.

## Interface
Parameters:
- SIB_SAMPLE_W, 8, bits per sample (one SHAKE byte)
- NUM_SAMPLES, 4, samples per input word; 64 must be divisible by NUM_SAMPLES·SIB_SAMPLE_W
- TAU, 60, number of nonzero coefficients; legal range 1..64
- N, 256, polynomial length; index width IDX_W = 8

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- zeroize  in  1  synchronous clear of all state and outputs
- start_i  in  1  single-cycle pulse that begins an operation
- data_valid_i  in  1  input word valid
- data_i  in  NUM_SAMPLES·SIB_SAMPLE_W  SHAKE word; lane 0 = bits [7:0] = earliest byte
- data_ready_o  out  1  input word accepted when valid & ready
- swap_valid_o  out  1  swap command valid
- swap_i_o  out  IDX_W  destination index i
- swap_j_o  out  IDX_W  sampled index j (j ≤ i)
- swap_sign_o  out  1  1 → c[j] = −1; 0 → c[j] = +1
- swap_ready_i  in  1  downstream accepts swap
- busy_o  out  1  operation in progress
- done_o  out  1  single-cycle pulse after the last swap is accepted

## Operation
- Reset/zeroize: FSM=IDLE. All outputs 0, lane buffer empty, sign register 0.
- FSM states:
  - IDLE: start_i → SIGN; i ← N−TAU; sign_cnt ← 0.
  - SIGN: accept 64/(NUM_SAMPLES·8) words into the 64-bit sign register, little-endian (first byte = bits [7:0]), then → SAMPLE.
  - SAMPLE: process buffered lanes one per cycle, in lane order.
  - DONE: pulse done_o for one cycle, then → IDLE.
- Lane buffer: holds one word plus a lane pointer. Per-lane test is valid & (byte ≤ i).
  - Pass: emit swap (i, j=byte, sign=sign_reg[i−(N−TAU)]), then i ← i+1.
  - Fail: discard the lane; i is unchanged.
- The pointer advances only when the current lane is consumed: a reject, or a pass whose swap slot is free or being drained this cycle.
- After the swap with i = N−1 is accepted → DONE. Remaining buffered lanes and in-flight input are discarded; data_ready_o stays 0.
- start_i while busy_o = 1 is ignored.
- i never exceeds N−1. The compare is unsigned, at IDX_W bits.

## Timing
- data_ready_o = 1 in SIGN, and in SAMPLE when the buffer is empty or its last lane is consumed this cycle (no bubble between words).
- Swap output is a registered single-entry slot. swap_valid_o rises the cycle after the lane is evaluated and holds with stable fields until swap_ready_i.
- Throughput: one lane per cycle when swap_ready_i = 1.
- Minimum latency, start_i → first swap_valid_o: 1 + sign words + 1 + 1 cycles.
- done_o rises the cycle after the final swap handshake.
- busy_o = 1 from the cycle after start_i until the cycle done_o is high, inclusive.
- Asynchronous rst mid-operation: outputs go to 0 immediately, FSM goes to IDLE, and the partial challenge is abandoned. Zeroize behaves the same at the next clock edge.

## Structure
- Package abr_sib_pkg: SIB_SAMPLE_W, N, IDX_W, the FSM state enum, and the swap command struct {i, j, sign}.
- The per-lane comparison instantiates the existing single-sample comparator sample_in_ball (valid_i = lane valid, rej_value_i = i).
- Sub-module sib_lane_buffer: word register, lane pointer, and empty/last-lane flags.

## Test plan
- TAU=60, all sample bytes 0x00 → 60 swaps with j=0 and i=196..255 in order, then done_o. Signs match sign_reg bits 0..59.
- Sign word 0x0000_0000_0000_0001, first sample 0xFF at i=196 → rejected, no swap. Next byte 0x05 → swap (196, 5, sign=1).
- swap_ready_i held low for 10 cycles with the buffer full → data_ready_o = 0 and swap fields stable. On release, continues at one swap per cycle.
- Final accepted sample in lane 1 of 4 → lanes 2–3 discarded, done_o exactly once, data_ready_o = 0 afterward.
- rst asserted mid-SAMPLE at i=220 → busy_o and swap_valid_o = 0 immediately. A new start_i restarts at i=196 and requires new sign words.
- start_i pulsed during SAMPLE → ignored, sequence unchanged. zeroize in SIGN → IDLE, sign register = 0.
